// File: rtl/lucid64_pkg.sv
// Shared types for the Lucid64 memory-side blocks.
// Requester ids, arbiter states and the outstanding-tracker entry.
package lucid64_pkg;

   localparam int ADDRESS_WD = 32;

   typedef enum logic {
      SRC_IMEM = 1'b0,
      SRC_DMEM = 1'b1
   } src_e;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   typedef struct packed {
      src_e src;
      logic addr2;
   } trk_entry_t;

   localparam int TRK_W = $bits(trk_entry_t);

endpackage

// File: rtl/lucid64_outst_fifo.sv
// In-order FIFO tracking outstanding bus transactions.
// Count is held separately from the pointers so full/empty never alias.
module lucid64_outst_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q;
   logic [PW-1:0]    rd_q;
   logic [CW-1:0]    cnt_q;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem_q[rd_q];
   assign count   = cnt_q;

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_q] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= wrap_inc(wr_q);
         end
         if (do_pop) begin
            rd_q <= wrap_inc(rd_q);
         end
         if (do_push & ~do_pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (do_pop & ~do_push) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/lucid64_obi_arbiter.sv
// Two-to-one OBI arbiter sharing one 64-bit port between fetch and data.
// Responses are routed in order back to the issuing requester.
module lucid64_obi_arbiter
   import lucid64_pkg::*;
#(
   parameter int VADDR     = ADDRESS_WD,
   parameter int XLEN      = 64,
   parameter int MAX_OUTST = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             imem_req_i,
   output logic             imem_gnt_o,
   input  logic [VADDR-1:0] imem_addr_ai,
   output logic             imem_rvalid_o,
   output logic [31:0]      imem_rdata_o,
   input  logic             dmem_req_i,
   output logic             dmem_gnt_o,
   input  logic [VADDR-1:0] dmem_addr_ai,
   input  logic             dmem_we_ai,
   input  logic [7:0]       dmem_be_ai,
   input  logic [XLEN-1:0]  dmem_wdata_ai,
   output logic             dmem_rvalid_o,
   output logic [XLEN-1:0]  dmem_rdata_o,
   output logic             bus_req_o,
   input  logic             bus_gnt_i,
   output logic [VADDR-1:0] bus_addr_o,
   output logic             bus_we_o,
   output logic [7:0]       bus_be_o,
   output logic [XLEN-1:0]  bus_wdata_o,
   input  logic             bus_rvalid_i,
   input  logic [XLEN-1:0]  bus_rdata_i,
   output logic             protocol_err_o
);

   localparam int CW = $clog2(MAX_OUTST + 1);

   arb_state_e state_q, state_d;
   src_e       lock_src_q;
   src_e       last_src_q;
   src_e       sel;
   logic       err_q;
   logic       room;
   logic       hs;
   logic       rsp;
   logic       trk_empty;
   logic [CW-1:0] trk_count;
   trk_entry_t push_e;
   trk_entry_t head_e;
   logic [TRK_W-1:0] head_raw;

   lucid64_outst_fifo #(
      .DEPTH(MAX_OUTST),
      .WIDTH(TRK_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (hs),
      .push_data (push_e),
      .pop       (rsp),
      .head      (head_raw),
      .count     (trk_count),
      .empty     (trk_empty)
   );

   assign head_e = head_raw;
   assign room   = ~reset & (trk_count < CW'(MAX_OUTST));

   // A locked choice is frozen until the bus grants it.
   always_comb begin
      sel = SRC_IMEM;
      if (state_q == ARB_LOCKED) begin
         sel = lock_src_q;
      end else if (imem_req_i & dmem_req_i) begin
         sel = (last_src_q == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
      end else if (dmem_req_i) begin
         sel = SRC_DMEM;
      end
   end

   always_comb begin
      bus_req_o   = room & ((sel == SRC_DMEM) ? dmem_req_i : imem_req_i);
      bus_addr_o  = '0;
      bus_we_o    = 1'b0;
      bus_be_o    = 8'h00;
      bus_wdata_o = '0;
      if (bus_req_o) begin
         if (sel == SRC_DMEM) begin
            bus_addr_o  = dmem_addr_ai;
            bus_we_o    = dmem_we_ai;
            bus_be_o    = dmem_be_ai;
            bus_wdata_o = dmem_wdata_ai;
         end else begin
            bus_addr_o = imem_addr_ai;
            bus_be_o   = imem_addr_ai[2] ? 8'hF0 : 8'h0F;
         end
      end
   end

   assign hs         = bus_req_o & bus_gnt_i;
   assign imem_gnt_o = hs & (sel == SRC_IMEM);
   assign dmem_gnt_o = hs & (sel == SRC_DMEM);

   always_comb begin
      push_e.src   = sel;
      push_e.addr2 = (sel == SRC_DMEM) ? dmem_addr_ai[2] : imem_addr_ai[2];
   end

   assign rsp = ~reset & bus_rvalid_i & ~trk_empty;

   always_comb begin
      imem_rvalid_o = 1'b0;
      imem_rdata_o  = '0;
      dmem_rvalid_o = 1'b0;
      dmem_rdata_o  = '0;
      if (rsp) begin
         if (head_e.src == SRC_DMEM) begin
            dmem_rvalid_o = 1'b1;
            dmem_rdata_o  = bus_rdata_i;
         end else begin
            imem_rvalid_o = 1'b1;
            imem_rdata_o  = head_e.addr2 ? bus_rdata_i[63:32]
                                         : bus_rdata_i[31:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (bus_req_o & ~bus_gnt_i) begin
               state_d = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            if (bus_gnt_i | ~bus_req_o) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         lock_src_q <= SRC_IMEM;
         last_src_q <= SRC_IMEM;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == ARB_IDLE) & (state_d == ARB_LOCKED)) begin
            lock_src_q <= sel;
         end
         if (hs) begin
            last_src_q <= sel;
         end
         if (bus_rvalid_i & trk_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   assign protocol_err_o = err_q & ~reset;

endmodule

// File: tb/tb_lucid64_obi_arbiter.sv
// Directed bench for lucid64_obi_arbiter.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_lucid64_obi_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_i;
  logic        imem_gnt_o;
  logic [31:0] imem_addr_ai;
  logic        imem_rvalid_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_req_i;
  logic        dmem_gnt_o;
  logic [31:0] dmem_addr_ai;
  logic        dmem_we_ai;
  logic [7:0]  dmem_be_ai;
  logic [63:0] dmem_wdata_ai;
  logic        dmem_rvalid_o;
  logic [63:0] dmem_rdata_o;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [7:0]  bus_be_o;
  logic [63:0] bus_wdata_o;
  logic        bus_rvalid_i;
  logic [63:0] bus_rdata_i;
  logic        protocol_err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  lucid64_obi_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_i     (imem_req_i),
    .imem_gnt_o     (imem_gnt_o),
    .imem_addr_ai   (imem_addr_ai),
    .imem_rvalid_o  (imem_rvalid_o),
    .imem_rdata_o   (imem_rdata_o),
    .dmem_req_i     (dmem_req_i),
    .dmem_gnt_o     (dmem_gnt_o),
    .dmem_addr_ai   (dmem_addr_ai),
    .dmem_we_ai     (dmem_we_ai),
    .dmem_be_ai     (dmem_be_ai),
    .dmem_wdata_ai  (dmem_wdata_ai),
    .dmem_rvalid_o  (dmem_rvalid_o),
    .dmem_rdata_o   (dmem_rdata_o),
    .bus_req_o      (bus_req_o),
    .bus_gnt_i      (bus_gnt_i),
    .bus_addr_o     (bus_addr_o),
    .bus_we_o       (bus_we_o),
    .bus_be_o       (bus_be_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rvalid_i   (bus_rvalid_i),
    .bus_rdata_i    (bus_rdata_i),
    .protocol_err_o (protocol_err_o)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_req_i    = 1'b0;
    imem_addr_ai  = '0;
    dmem_req_i    = 1'b0;
    dmem_addr_ai  = '0;
    dmem_we_ai    = 1'b0;
    dmem_be_ai    = '0;
    dmem_wdata_ai = '0;
    bus_gnt_i     = 1'b0;
    bus_rvalid_i  = 1'b0;
    bus_rdata_i   = '0;
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    imem_req_i = 1'b1;
    cyc();
    #1;
    chk("rst_bus_req", bus_req_o, 1'b0);
    chk("rst_be", bus_be_o, 8'h00);
    chk("rst_err", protocol_err_o, 1'b0);
    imem_req_i = 1'b0;
    cyc();
    reset = 1'b0;
    #1;
    chk("post_rst_outs",
        {bus_req_o, imem_gnt_o, dmem_gnt_o, imem_rvalid_o,
         dmem_rvalid_o, protocol_err_o, bus_addr_o}, 38'h0);

    cyc();
    imem_req_i   = 1'b1;
    imem_addr_ai = 32'h1004;
    bus_gnt_i    = 1'b1;
    #1;
    chk("fetch_be", bus_be_o, 8'hF0);
    chk("fetch_addr", bus_addr_o, 32'h1004);
    chk("fetch_we", bus_we_o, 1'b0);
    chk("fetch_ignt", imem_gnt_o, 1'b1);
    chk("fetch_dgnt", dmem_gnt_o, 1'b0);
    cyc();
    imem_req_i = 1'b0;
    bus_gnt_i  = 1'b0;
    #1;
    chk("fetch_gnt_once", imem_gnt_o, 1'b0);
    cyc();
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    chk("fetch_rvalid", imem_rvalid_o, 1'b1);
    chk("fetch_rdata", imem_rdata_o, 32'hAAAABBBB);
    chk("fetch_no_drv", dmem_rvalid_o, 1'b0);
    cyc();
    bus_rvalid_i = 1'b0;
    #1;
    chk("fetch_no_err", protocol_err_o, 1'b0);

    do_reset();
    imem_req_i    = 1'b1;
    imem_addr_ai  = 32'h3000;
    dmem_req_i    = 1'b1;
    dmem_addr_ai  = 32'h2000;
    dmem_we_ai    = 1'b1;
    dmem_be_ai    = 8'hFF;
    dmem_wdata_ai = 64'h1111;
    bus_gnt_i     = 1'b1;
    #1;
    chk("tie1_dgnt", dmem_gnt_o, 1'b1);
    chk("tie1_igнт", imem_gnt_o, 1'b0);
    chk("tie1_wdata", bus_wdata_o, 64'h1111);
    chk("tie1_we", bus_we_o, 1'b1);
    cyc();
    #1;
    chk("tie2_igнт", imem_gnt_o, 1'b1);
    chk("tie2_be", bus_be_o, 8'h0F);
    chk("tie2_wdata", bus_wdata_o, 64'h0);
    cyc();
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 64'h0000_0001_0000_0002;
    #1;
    chk("tie3_full", bus_req_o, 1'b0);
    chk("tie3_drv", dmem_rvalid_o, 1'b1);
    chk("tie3_drdata", dmem_rdata_o, 64'h0000_0001_0000_0002);
    chk("tie3_irv", imem_rvalid_o, 1'b0);
    cyc();
    bus_rdata_i = 64'h0000_0003_0000_0004;
    #1;
    chk("tie4_dgnt", dmem_gnt_o, 1'b1);
    chk("tie4_irv", imem_rvalid_o, 1'b1);
    chk("tie4_irdata", imem_rdata_o, 32'h4);
    cyc();
    bus_rdata_i = 64'h0000_0005_0000_0006;
    #1;
    chk("tie5_igнт", imem_gnt_o, 1'b1);
    chk("tie5_drv", dmem_rvalid_o, 1'b1);
    chk("tie5_drdata", dmem_rdata_o, 64'h0000_0005_0000_0006);
    cyc();
    imem_req_i  = 1'b0;
    dmem_req_i  = 1'b0;
    bus_gnt_i   = 1'b0;
    bus_rdata_i = 64'h0000_0007_0000_0008;
    #1;
    chk("tie6_irv", imem_rvalid_o, 1'b1);
    chk("tie6_irdata", imem_rdata_o, 32'h8);
    cyc();
    bus_rvalid_i = 1'b0;
    #1;
    chk("tie7_no_err", protocol_err_o, 1'b0);

    do_reset();
    dmem_req_i    = 1'b1;
    dmem_addr_ai  = 32'h2008;
    dmem_we_ai    = 1'b1;
    dmem_be_ai    = 8'hF0;
    dmem_wdata_ai = 64'h5555;
    #1;
    chk("lock1_addr", bus_addr_o, 32'h2008);
    chk("lock1_dgnt", dmem_gnt_o, 1'b0);
    cyc();
    imem_req_i   = 1'b1;
    imem_addr_ai = 32'h4000;
    #1;
    chk("lock2_addr", bus_addr_o, 32'h2008);
    chk("lock2_wdata", bus_wdata_o, 64'h5555);
    cyc();
    #1;
    chk("lock3_addr", bus_addr_o, 32'h2008);
    chk("lock3_igнт", imem_gnt_o, 1'b0);
    cyc();
    bus_gnt_i = 1'b1;
    #1;
    chk("lock4_dgnt", dmem_gnt_o, 1'b1);
    chk("lock4_addr", bus_addr_o, 32'h2008);
    cyc();
    #1;
    chk("lock5_igнт", imem_gnt_o, 1'b1);
    chk("lock5_addr", bus_addr_o, 32'h4000);
    cyc();
    #1;
    chk("full_req", bus_req_o, 1'b0);
    chk("full_dgnt", dmem_gnt_o, 1'b0);
    cyc();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 64'h99;
    #1;
    chk("full_nobypass", bus_req_o, 1'b0);
    chk("full_drv", dmem_rvalid_o, 1'b1);
    cyc();
    bus_rvalid_i = 1'b0;
    #1;
    chk("full_reopen", bus_req_o, 1'b1);
    chk("full_rr_dmem", bus_addr_o, 32'h2008);

    do_reset();
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 64'hDEAD;
    #1;
    chk("stray_irv", imem_rvalid_o, 1'b0);
    chk("stray_drv", dmem_rvalid_o, 1'b0);
    cyc();
    bus_rvalid_i = 1'b0;
    #1;
    chk("stray_err", protocol_err_o, 1'b1);
    cyc();
    cyc();
    #1;
    chk("stray_sticky", protocol_err_o, 1'b1);
    do_reset();
    #1;
    chk("stray_cleared", protocol_err_o, 1'b0);

    imem_req_i   = 1'b1;
    imem_addr_ai = 32'h10;
    bus_gnt_i    = 1'b1;
    #1;
    chk("midrst_gnt", imem_gnt_o, 1'b1);
    do_reset();
    bus_rvalid_i = 1'b1;
    #1;
    chk("midrst_irv", imem_rvalid_o, 1'b0);
    cyc();
    bus_rvalid_i = 1'b0;
    #1;
    chk("midrst_err", protocol_err_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/lucid64_obi_arbiter.md
# lucid64_obi_arbiter

Two-to-one OBI (RI5CY subset) arbiter that shares one 64-bit memory port between the Lucid64 instruction-fetch and data-memory interfaces. It sits between the core's `imem_*`/`dmem_*` ports and a single unified bus, such as a shared SRAM or the formal memory model. It tracks outstanding transactions in order and routes each `rvalid` response back to the requester that issued it. The arbiter adds no cycles of latency in either direction.

## Interface
Parameters:
- `VADDR`, default `ADDRESS_WD`: address width on all three ports.
- `XLEN`, default 64: data width on the dmem side and the bus side.
- `MAX_OUTST`, default 2: depth of the outstanding-transaction tracker (≥1).

Ports:
- `clock` in 1: single clock; all state on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req_i` in 1, `imem_gnt_o` out 1, `imem_addr_ai` in VADDR: fetch request channel.
- `imem_rvalid_o` out 1, `imem_rdata_o` out 32: fetch response channel.
- `dmem_req_i` in 1, `dmem_gnt_o` out 1, `dmem_addr_ai` in VADDR, `dmem_we_ai` in 1, `dmem_be_ai` in 8, `dmem_wdata_ai` in XLEN: data request channel.
- `dmem_rvalid_o` out 1, `dmem_rdata_o` out XLEN: data response channel.
- `bus_req_o` out 1, `bus_gnt_i` in 1, `bus_addr_o` out VADDR, `bus_we_o` out 1, `bus_be_o` out 8, `bus_wdata_o` out XLEN: shared request channel.
- `bus_rvalid_i` in 1, `bus_rdata_i` in XLEN: shared response channel.
- `protocol_err_o` out 1: sticky flag, set on `bus_rvalid_i` with no outstanding transaction.

## Operation
- **Eligibility.** A requester is eligible when its req is high and tracker count < `MAX_OUTST`. There is no bypass: a pop in the same cycle does not free a slot for a push.
- **States.** The arbiter has two states, IDLE and LOCKED.
  - IDLE → LOCKED when `bus_req_o` is high and `bus_gnt_i` is low. The chosen requester is held in `lock_src`.
  - LOCKED → IDLE on `bus_gnt_i`.
  - While LOCKED, the choice cannot change, so the OBI rule that address and data stay stable until grant holds at the bus.
- **Selection in IDLE.** Round-robin between eligible requesters. The requester granted most recently loses a tie. `last_src` resets to IMEM, so dmem wins the first tie.
- **Request mux.**
  - When dmem is selected, its addr/we/be/wdata pass straight to the bus.
  - When imem is selected, the bus sees addr = `imem_addr_ai`, we = 0, wdata = 0.
  - For imem, be = 8'h0F when addr[2] = 0, and 8'hF0 otherwise.
- **Grant.** `imem_gnt_o` / `dmem_gnt_o` = `bus_gnt_i` AND `bus_req_o` AND (selected source). At most one grant is high per cycle.
- **Tracker.** An in-order FIFO of {src, addr[2]}.
  - Push on every bus handshake.
  - Pop on `bus_rvalid_i` when the FIFO is not empty.
- **Response routing** follows the FIFO head:
  - head src = DMEM: `dmem_rvalid_o` = `bus_rvalid_i` and `dmem_rdata_o` = `bus_rdata_i`. Write responses route the same way.
  - head src = IMEM: `imem_rvalid_o` = `bus_rvalid_i` and `imem_rdata_o` = `bus_rdata_i`[32·addr2 +: 32].
- **Simultaneous handshake and response.** When a handshake and a response occur in the same cycle, push and pop both happen and the count is unchanged. A response cannot belong to the request granted in that same cycle.
- **Stray response.** `bus_rvalid_i` with an empty FIFO:
  - It is dropped; both rvalid outputs stay 0.
  - `protocol_err_o` is set and held until reset.
- **Pointer wrap.** FIFO pointers wrap modulo `MAX_OUTST`. The count is kept separately, so full and empty are unambiguous.

## Timing
- **Reset values.** All outputs are 0 during and after reset. State resets to IDLE, the FIFO to empty, `last_src` to IMEM and `protocol_err_o` to 0.
- **Reset mid-operation.** Outstanding entries are discarded. Any `bus_rvalid_i` that arrives after reset raises `protocol_err_o`.
- **Request path.** Purely combinational from requester inputs and state to the bus. A grant is visible in the same cycle as `bus_gnt_i`.
- **Response path.** Combinational from `bus_rvalid_i`/`bus_rdata_i` and the FIFO head. There is zero added latency.
- **Outstanding limit.** At most `MAX_OUTST` transactions are outstanding. `bus_req_o` is low whenever the tracker is full.

## Structure
- The shared package `lucid64_pkg` holds:
  - the `src_e` enum {SRC_IMEM, SRC_DMEM};
  - the `arb_state_e` enum {ARB_IDLE, ARB_LOCKED};
  - the tracker entry struct {src_e src; logic addr2;}.
- One sub-module, `lucid64_outst_fifo`: a parameterised in-order FIFO with push/pop, head, count, full and empty.
- The `rvfi_wrapper` variant with a unified memory instantiates this block between the DUT and the random bus inputs.

## Test plan
- **Fetch path.** imem req at addr 0x1004, bus_gnt the same cycle, rvalid 2 cycles later with rdata 0xAAAA_BBBB_CCCC_DDDD.
  - → be = 0xF0, imem_gnt 1 cycle, imem_rdata = 0xAAAABBBB, dmem_rvalid stays 0.
- **First tie.** Both requests high from reset, gnt always high.
  - → grant order dmem, imem, dmem, imem.
  - → responses return in that order to the matching ports.
- **Lock.** dmem wins, bus_gnt held low 3 cycles, imem req asserted meanwhile.
  - → bus_addr/wdata stay on dmem values for all 3 cycles; imem is granted on the next cycle after the dmem grant.
- **Full tracker.** `MAX_OUTST` = 2, two grants, no rvalid.
  - → bus_req_o = 0 even with both reqs high.
  - → one rvalid re-enables bus_req_o on the following cycle.
- **Push and pop together.** A grant and a response in the same cycle.
  - → count unchanged; the response goes to the older entry.
- **Stray response, then reset.** rvalid with an empty tracker.
  - → both rvalid outputs stay 0 and protocol_err_o goes to 1 and stays there.
  - → reset clears it.
